// File: rtl/beep_alarm_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | beep_alarm_ctrl_if : alarm requests in, buzzer tone control out  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface beep_alarm_ctrl_if;
  logic        req_temp;
  logic        req_humi;
  logic        req_key;
  logic        mute;
  logic        tone_en;
  logic [17:0] freq_data;
  logic [1:0]  grant;
  logic        busy;

  modport master (
    output req_temp, req_humi, req_key, mute,
    input  tone_en, freq_data, grant, busy
  );

  modport slave (
    input  req_temp, req_humi, req_key, mute,
    output tone_en, freq_data, grant, busy
  );
endinterface
`default_nettype wire

// File: rtl/beep_alarm_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | beep_alarm_ctrl : priority arbiter/sequencer sharing one buzzer   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module beep_alarm_ctrl #(
  parameter logic [22:0] TIME_UNIT = 23'd4999999,
  parameter logic [17:0] TONE_HI   = 18'd113635,
  parameter logic [17:0] TONE_LO   = 18'd190839,
  parameter logic [17:0] TONE_CLK  = 18'd101214
) (
  input wire logic         sys_clk,
  input wire logic         sys_rst,
  beep_alarm_ctrl_if.slave bus
);

  // Encoding doubles as the grant code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    KEY  = 2'b01,
    HUMI = 2'b10,
    TEMP = 2'b11
  } state_e;

  state_e      state_q, state_d, win;
  logic [22:0] cnt_q, cnt_d;
  logic [3:0]  seg_q, seg_d, last_seg;
  logic        temp_q, humi_q;
  logic        key_pend_q, key_pend_d;
  logic        preempt_q, preempt_d;
  logic        tone_en_q, tone_en_d;
  logic [17:0] freq_q, freq_d;
  logic        wrap, enter, on_d;

  always_comb begin
    win = IDLE;
    if (temp_q)          win = TEMP;
    else if (humi_q)     win = HUMI;
    else if (key_pend_q) win = KEY;
  end

  always_comb begin
    last_seg = 4'd0;
    case (state_q)
      TEMP:    last_seg = 4'd7;
      HUMI:    last_seg = 4'd11;
      default: last_seg = 4'd0;
    endcase
  end

  assign wrap = (cnt_q == TIME_UNIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 23'd1;
    seg_d   = seg_q;
    enter   = 1'b0;
    if (state_q == IDLE || (wrap && seg_q == last_seg)) begin
      state_d = win;
      enter   = 1'b1;
    end else if (wrap && preempt_q) begin
      state_d = TEMP;
      enter   = 1'b1;
    end else if (wrap) begin
      cnt_d = '0;
      seg_d = seg_q + 4'd1;
    end
    if (enter) begin
      cnt_d = '0;
      seg_d = '0;
    end

    // A pulse on the grant cycle must survive the clear.
    key_pend_d = key_pend_q | bus.req_key;
    if (enter && state_d == KEY) key_pend_d = bus.req_key;

    preempt_d = (state_d == HUMI || state_d == KEY) &&
                (bus.req_temp || (preempt_q && !enter));
  end

  // Tone for the unit being entered; silent units keep the last divider.
  always_comb begin
    on_d   = 1'b0;
    freq_d = freq_q;
    case (state_d)
      TEMP: begin
        if (seg_d < 4'd3) begin
          on_d   = 1'b1;
          freq_d = TONE_HI;
        end else if (seg_d < 4'd6) begin
          on_d   = 1'b1;
          freq_d = TONE_LO;
        end
      end
      HUMI: begin
        if (seg_d < 4'd2 || seg_d == 4'd4 || seg_d == 4'd5) begin
          on_d   = 1'b1;
          freq_d = TONE_HI;
        end
      end
      KEY: begin
        on_d   = 1'b1;
        freq_d = TONE_CLK;
      end
      default: ;
    endcase
    tone_en_d = on_d & ~bus.mute;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      seg_q      <= '0;
      temp_q     <= 1'b0;
      humi_q     <= 1'b0;
      key_pend_q <= 1'b0;
      preempt_q  <= 1'b0;
      tone_en_q  <= 1'b0;
      freq_q     <= TONE_LO;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      temp_q     <= bus.req_temp;
      humi_q     <= bus.req_humi;
      key_pend_q <= key_pend_d;
      preempt_q  <= preempt_d;
      tone_en_q  <= tone_en_d;
      freq_q     <= freq_d;
    end
  end

  assign bus.tone_en   = tone_en_q;
  assign bus.freq_data = freq_q;
  assign bus.grant     = state_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_beep_alarm_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_beep_alarm_ctrl : directed segment table for beep_alarm_ctrl  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_beep_alarm_ctrl;

  localparam logic [17:0] HI = 18'd113635;
  localparam logic [17:0] LO = 18'd190839;
  localparam logic [17:0] CK = 18'd101214;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_chk   = 0;
  int   n_fail  = 0;

  beep_alarm_ctrl_if bus ();

  beep_alarm_ctrl #(
    .TIME_UNIT (23'd9),
    .TONE_HI   (HI),
    .TONE_LO   (LO),
    .TONE_CLK  (CK)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs are held for n clocks; outputs must match after every one of them.
  typedef struct {
    string       name;
    logic        rst, temp, humi, key, mute;
    int          n;
    logic        en;
    logic [17:0] freq;
    logic [1:0]  gnt;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic rst, input logic temp,
                              input logic humi, input logic key, input logic mute,
                              input int n, input logic en, input logic [17:0] freq,
                              input logic [1:0] gnt, input logic busy);
    vec_t v;
    v.name = nm; v.rst = rst; v.temp = temp; v.humi = humi; v.key = key; v.mute = mute;
    v.n = n; v.en = en; v.freq = freq; v.gnt = gnt; v.busy = busy;
    return v;
  endfunction

  task automatic run_seg(input vec_t v);
    sys_rst      = v.rst;
    bus.req_temp = v.temp;
    bus.req_humi = v.humi;
    bus.req_key  = v.key;
    bus.mute     = v.mute;
    for (int c = 0; c < v.n; c++) begin
      @(posedge sys_clk);
      #1;
      n_chk++;
      if ({bus.tone_en, bus.freq_data, bus.grant, bus.busy} !== {v.en, v.freq, v.gnt, v.busy}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got en=%b freq=%0d grant=%b busy=%b, expected en=%b freq=%0d grant=%b busy=%b",
                 v.name, c, bus.tone_en, bus.freq_data, bus.grant, bus.busy,
                 v.en, v.freq, v.gnt, v.busy);
      end
    end
  endtask

  initial begin
    bus.req_temp = 1'b0;
    bus.req_humi = 1'b0;
    bus.req_key  = 1'b0;
    bus.mute     = 1'b0;

    //                name          rst tmp hum key mut   n  en freq gnt   busy
    tbl.push_back(mk("reset",        1, 0, 0, 0, 0,   2, 0, LO, 2'b00, 0));
    tbl.push_back(mk("reset_rel",    0, 0, 0, 0, 0,   2, 0, LO, 2'b00, 0));
    // single click
    tbl.push_back(mk("key_pulse",    0, 0, 0, 1, 0,   1, 0, LO, 2'b00, 0));
    tbl.push_back(mk("key_click",    0, 0, 0, 0, 0,  10, 1, CK, 2'b01, 1));
    tbl.push_back(mk("key_idle",     0, 0, 0, 0, 0,   3, 0, CK, 2'b00, 0));
    // second pulse lands on the grant cycle: two clicks back to back
    tbl.push_back(mk("dkey_pulse",   0, 0, 0, 1, 0,   1, 0, CK, 2'b00, 0));
    tbl.push_back(mk("dkey_grant",   0, 0, 0, 1, 0,   1, 1, CK, 2'b01, 1));
    tbl.push_back(mk("dkey_click",   0, 0, 0, 0, 0,  19, 1, CK, 2'b01, 1));
    tbl.push_back(mk("dkey_idle",    0, 0, 0, 0, 0,   2, 0, CK, 2'b00, 0));
    // temp held 200 clocks
    tbl.push_back(mk("temp_req",     0, 1, 0, 0, 0,   1, 0, CK, 2'b00, 0));
    for (int p = 0; p < 2; p++) begin
      tbl.push_back(mk("temp_hi",    0, 1, 0, 0, 0,  30, 1, HI, 2'b11, 1));
      tbl.push_back(mk("temp_lo",    0, 1, 0, 0, 0,  30, 1, LO, 2'b11, 1));
      tbl.push_back(mk("temp_off",   0, 1, 0, 0, 0,  20, 0, LO, 2'b11, 1));
    end
    tbl.push_back(mk("temp3_hi",     0, 1, 0, 0, 0,  30, 1, HI, 2'b11, 1));
    tbl.push_back(mk("temp3_lo",     0, 1, 0, 0, 0,   9, 1, LO, 2'b11, 1));
    tbl.push_back(mk("temp3_lo_rel", 0, 0, 0, 0, 0,  21, 1, LO, 2'b11, 1));
    tbl.push_back(mk("temp3_off",    0, 0, 0, 0, 0,  20, 0, LO, 2'b11, 1));
    tbl.push_back(mk("temp_idle",    0, 0, 0, 0, 0,   2, 0, LO, 2'b00, 0));
    // temp and key together, temp dropped at clock 5
    tbl.push_back(mk("tk_req",       0, 1, 0, 1, 0,   1, 0, LO, 2'b00, 0));
    tbl.push_back(mk("tk_hi_held",   0, 1, 0, 0, 0,   5, 1, HI, 2'b11, 1));
    tbl.push_back(mk("tk_hi",        0, 0, 0, 0, 0,  25, 1, HI, 2'b11, 1));
    tbl.push_back(mk("tk_lo",        0, 0, 0, 0, 0,  30, 1, LO, 2'b11, 1));
    tbl.push_back(mk("tk_off",       0, 0, 0, 0, 0,  20, 0, LO, 2'b11, 1));
    tbl.push_back(mk("tk_click",     0, 0, 0, 0, 0,  10, 1, CK, 2'b01, 1));
    tbl.push_back(mk("tk_idle",      0, 0, 0, 0, 0,   2, 0, CK, 2'b00, 0));
    // humi muted for one full period, then one audible period
    tbl.push_back(mk("mute_req",     0, 0, 1, 0, 1,   1, 0, CK, 2'b00, 0));
    tbl.push_back(mk("mute_humi",    0, 0, 1, 0, 1, 120, 0, HI, 2'b10, 1));
    tbl.push_back(mk("humi_hi1",     0, 0, 0, 0, 0,  20, 1, HI, 2'b10, 1));
    tbl.push_back(mk("humi_off1",    0, 0, 0, 0, 0,  20, 0, HI, 2'b10, 1));
    tbl.push_back(mk("humi_hi2",     0, 0, 0, 0, 0,  20, 1, HI, 2'b10, 1));
    tbl.push_back(mk("humi_off2",    0, 0, 0, 0, 0,  60, 0, HI, 2'b10, 1));
    tbl.push_back(mk("humi_idle",    0, 0, 0, 0, 0,   2, 0, HI, 2'b00, 0));

    for (int i = 0; i < tbl.size(); i++) run_seg(tbl[i]);

    // temp raised at clock 25 of HUMI takes over at the unit wrap (clock 30)
    run_seg(mk("pre_req",      0, 0, 1, 0, 0,  1, 0, HI, 2'b00, 0));
    run_seg(mk("pre_humi_hi",  0, 0, 1, 0, 0, 20, 1, HI, 2'b10, 1));
    run_seg(mk("pre_humi_off", 0, 0, 1, 0, 0,  5, 0, HI, 2'b10, 1));
    run_seg(mk("pre_raise",    0, 1, 1, 0, 0,  5, 0, HI, 2'b10, 1));
    run_seg(mk("pre_temp_hi",  0, 1, 1, 0, 0, 30, 1, HI, 2'b11, 1));
    run_seg(mk("pre_temp_lo",  0, 0, 0, 0, 0, 30, 1, LO, 2'b11, 1));
    run_seg(mk("pre_temp_off", 0, 0, 0, 0, 0, 20, 0, LO, 2'b11, 1));
    run_seg(mk("pre_idle",     0, 0, 0, 0, 0,  2, 0, LO, 2'b00, 0));

    // reset at clock 45 of TEMP with a click pending: no click afterwards
    run_seg(mk("rst_req",      0, 1, 0, 1, 0,  1, 0, LO, 2'b00, 0));
    run_seg(mk("rst_temp_hi",  0, 1, 0, 0, 0, 30, 1, HI, 2'b11, 1));
    run_seg(mk("rst_temp_lo",  0, 1, 0, 0, 0, 15, 1, LO, 2'b11, 1));
    run_seg(mk("rst_mid",      1, 0, 0, 0, 0,  1, 0, LO, 2'b00, 0));
    run_seg(mk("rst_no_click", 0, 0, 0, 0, 0, 15, 0, LO, 2'b00, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/beep_alarm_ctrl.md
Name: beep_alarm_ctrl

Overview:
- Sequencer and arbiter that shares the single buzzer tone generator among three alarm sources: temperature over-limit, humidity over-limit and key-press click.
- Selects one requester by fixed priority and plays that requester's on/off tone pattern in 100 ms units.
- Drives the tone generator's divider value (freq_data) and enable (tone_en).
- Sits between the DHT11 threshold-compare logic / key debouncer and the buzzer tone generator.

Parameters:
- TIME_UNIT, 23'd4999999: pattern unit length minus 1, in clocks (100 ms at 50 MHz).
- TONE_HI, 18'd113635: divider for the alarm high tone (440 Hz).
- TONE_LO, 18'd190839: divider for the alarm low tone (262 Hz).
- TONE_CLK, 18'd101214: divider for the key click (494 Hz).

Ports:
- sys_clk, input, 1: system clock, 50 MHz.
- sys_rst, input, 1: synchronous reset, active-high.
- req_temp, input, 1: level; temperature alarm active.
- req_humi, input, 1: level; humidity alarm active.
- req_key, input, 1: single-cycle pulse; key accepted.
- mute, input, 1: level; silences tone_en, sequencing continues.
- tone_en, output, 1: enable to tone generator.
- freq_data, output, 18: divider value to tone generator.
- grant, output, 2: active owner; 00 none, 01 key, 10 humi, 11 temp.
- busy, output, 1: high whenever state is not IDLE.

Behaviour:
- Reset (sys_rst=1 at a clock edge): state IDLE, tone_en=0, freq_data=TONE_LO, grant=00, busy=0, unit counter=0, segment index=0, key_pend=0.
- key_pend:
  - Set on any req_key=1 cycle.
  - Cleared on the cycle KEY is granted.
  - If a pulse arrives on the grant cycle, set wins and key_pend stays 1.
- Arbitration priority is temp > humi > key_pend. It is evaluated only:
  - in IDLE;
  - at pattern end (last clock of the last unit).
- States are IDLE, TEMP, HUMI, KEY. Entering a state zeroes the unit counter and the segment index.
- The unit counter counts 0..TIME_UNIT, then wraps. Each wrap advances the segment index.
- TEMP pattern, 8 units: units 0-2 TONE_HI on; units 3-5 TONE_LO on; units 6-7 silent.
- HUMI pattern, 12 units: units 0-1 TONE_HI on; units 2-3 silent; units 4-5 TONE_HI on; units 6-11 silent.
- KEY pattern, 1 unit: TONE_CLK on.
- Silent unit: tone_en=0 and freq_data holds its last value.
- Pattern end:
  - If the same level request is still high and it still wins arbitration, the pattern restarts at unit 0.
  - Otherwise the next winner is granted.
  - If nothing is requesting, the state goes to IDLE.
  - A level request that drops mid-pattern still completes the current pattern.
- Preemption: a req_temp sampled high while in HUMI or KEY switches to TEMP on the next unit-counter wrap, not at pattern end.
  - A preempted KEY click is discarded.
  - A preempted HUMI pattern is not resumed; HUMI re-arbitrates from unit 0 later if req_humi is still high.
- Latency:
  - A request sampled in IDLE at edge N gives state, grant, busy, tone_en and freq_data valid after edge N+1.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- tone_en = pattern_on AND NOT mute. mute does not change state, grant or timing.
- Simultaneous req_temp and req_key in IDLE: TEMP is granted and key_pend is retained. The click plays after TEMP ends, provided req_temp is low then.
- Reset mid-pattern: everything returns to reset values on the next edge, and key_pend is lost.

Test Plan:
- All tests use TIME_UNIT=9 (10 clocks per unit).
- Single key pulse in IDLE -> grant=01 and tone_en=1 with freq_data=TONE_CLK for exactly 10 clocks, then grant=00, busy=0.
- req_temp held for 200 clocks -> repeating 80-clock pattern: 30 clocks TONE_HI, 30 clocks TONE_LO, 20 clocks silent. After release the current pattern completes and the state goes to IDLE.
- req_humi held, then req_temp raised at clock 25 of HUMI -> grant switches 10->11 at clock 30 (unit wrap), and TEMP starts at unit 0 with TONE_HI.
- req_temp and req_key pulse on the same cycle in IDLE, req_temp dropped at clock 5 -> one 80-clock TEMP pattern, then a 10-clock TONE_CLK click, then IDLE.
- req_humi held with mute=1 -> tone_en stays 0; grant=10, busy=1, and the 120-clock period is unchanged.
- sys_rst asserted at clock 45 of TEMP with a key pending -> after the next edge all outputs are at reset values, and no click follows.
